// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for a 16-bit Galois LFSR.
// Loads a seed, steps N times while streaming bits, then pulses DONE.
module lfsr_seq_ctrl #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [WIDTH-1:0] RESET_SEED = 16'h0001
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] SEED,
    input  logic [CNT_W-1:0] NSTEPS,
    input  logic             HOLD,
    input  logic             ABORT,
    output logic [WIDTH-1:0] Q,
    output logic             BIT_OUT,
    output logic             BIT_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             SEED_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seed_err_q, seed_err_d;
    logic [WIDTH-1:0] q_step;

    assign q_step = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        seed_err_d  = seed_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    // A zero seed would lock the register, so substitute
                    if (SEED == '0) begin
                        q_d        = RESET_SEED;
                        seed_err_d = 1'b1;
                    end else begin
                        q_d        = SEED;
                        seed_err_d = 1'b0;
                    end
                    cnt_d = NSTEPS;
                    if (NSTEPS == '0) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (!HOLD) begin
                    q_d         = q_step;
                    bit_out_d   = q_q[0];
                    bit_valid_d = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            q_q         <= RESET_SEED;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign Q         = q_q;
    assign BIT_OUT   = bit_out_q;
    assign BIT_VALID = bit_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SEED_ERR  = seed_err_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_lfsr_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] SEED;
    logic [15:0] NSTEPS;
    logic        HOLD;
    logic        ABORT;
    logic [15:0] Q;
    logic        BIT_OUT;
    logic        BIT_VALID;
    logic        BUSY;
    logic        DONE;
    logic        SEED_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [4];
    logic        exp_b [4];

    lfsr_seq_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .SEED      (SEED),
        .NSTEPS    (NSTEPS),
        .HOLD      (HOLD),
        .ABORT     (ABORT),
        .Q         (Q),
        .BIT_OUT   (BIT_OUT),
        .BIT_VALID (BIT_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .SEED_ERR  (SEED_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [15:0] s, input logic [15:0] n);
        SEED   = s;
        NSTEPS = n;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        SEED   = 16'h5555;
        NSTEPS = 16'h0007;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        if (Q !== 16'h0001) begin n_fail++; $display("FAIL reset_q got %h exp 0001", Q); end
        n_checks++;
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        n_checks++;
        if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", DONE); end
        n_checks++;
        if (BIT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", BIT_VALID); end
        n_checks++;
        if (SEED_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_serr got %b exp 0", SEED_ERR); end
        n_checks++;
        if (BIT_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_bit got %b exp 0", BIT_OUT); end
        n_checks++;
        RST = 1'b0;
        tick();
        if (Q !== 16'h0001 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got q=%h busy=%b exp 0001/0", Q, BUSY);
        end
        n_checks++;
    endtask

    task automatic test_basic_run();
        int busy_cyc = 0;
        int act_cyc  = 0;
        launch(16'hACE1, 16'd4);
        if (Q !== 16'hACE1) begin n_fail++; $display("FAIL basic_load got %h exp ace1", Q); end
        n_checks++;
        if (BUSY !== 1'b1 || BIT_VALID !== 1'b0) begin
            n_fail++; $display("FAIL basic_accept got busy=%b v=%b exp 1/0", BUSY, BIT_VALID);
        end
        n_checks++;
        busy_cyc += int'(BUSY);
        act_cyc  += int'(BUSY | DONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            busy_cyc += int'(BUSY);
            act_cyc  += int'(BUSY | DONE);
            if (Q !== exp_q[i] || BIT_OUT !== exp_b[i] || BIT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_step%0d got q=%h b=%b v=%b exp %h/%b/1",
                         i, Q, BIT_OUT, BIT_VALID, exp_q[i], exp_b[i]);
            end
            n_checks++;
            if (DONE !== (i == 3) || BUSY !== (i != 3)) begin
                n_fail++;
                $display("FAIL basic_flags%0d got done=%b busy=%b", i, DONE, BUSY);
            end
            n_checks++;
        end
        tick();
        if (DONE !== 1'b0 || BIT_VALID !== 1'b0 || Q !== 16'h1C4E) begin
            n_fail++; $display("FAIL basic_fin got d=%b v=%b q=%h exp 0/0/1c4e", DONE, BIT_VALID, Q);
        end
        n_checks++;
        if (busy_cyc != 4 || act_cyc != 5) begin
            n_fail++; $display("FAIL basic_busy_len got %0d/%0d exp 4/5", busy_cyc, act_cyc);
        end
        n_checks++;
    endtask

    task automatic test_hold();
        launch(16'hACE1, 16'd4);
        tick();
        tick();
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Q !== 16'h7138 || BIT_VALID !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d got q=%h v=%b busy=%b d=%b exp 7138/0/1/0",
                         i, Q, BIT_VALID, BUSY, DONE);
            end
            n_checks++;
        end
        HOLD = 1'b0;
        tick();
        if (Q !== 16'h389C || BIT_VALID !== 1'b1 || DONE !== 1'b0) begin
            n_fail++; $display("FAIL hold_resume got q=%h v=%b d=%b exp 389c/1/0", Q, BIT_VALID, DONE);
        end
        n_checks++;
        tick();
        if (Q !== 16'h1C4E || DONE !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL hold_done got q=%h d=%b busy=%b exp 1c4e/1/0", Q, DONE, BUSY);
        end
        n_checks++;
        tick();
    endtask

    task automatic test_zero_seed();
        launch(16'h0000, 16'd1);
        if (Q !== 16'h0001 || SEED_ERR !== 1'b1 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL zseed_load got q=%h e=%b busy=%b exp 0001/1/1", Q, SEED_ERR, BUSY);
        end
        n_checks++;
        tick();
        if (Q !== 16'hB400 || BIT_OUT !== 1'b1 || BIT_VALID !== 1'b1 || DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL zseed_step got q=%h b=%b v=%b d=%b exp b400/1/1/1", Q, BIT_OUT, BIT_VALID, DONE);
        end
        n_checks++;
        tick();
        if (DONE !== 1'b0 || SEED_ERR !== 1'b1) begin
            n_fail++; $display("FAIL zseed_sticky got d=%b e=%b exp 0/1", DONE, SEED_ERR);
        end
        n_checks++;
    endtask

    task automatic test_nsteps_zero();
        launch(16'hBEEF, 16'd0);
        if (Q !== 16'hBEEF || DONE !== 1'b1 || BUSY !== 1'b0 || BIT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL n0_done got q=%h d=%b busy=%b v=%b exp beef/1/0/0", Q, DONE, BUSY, BIT_VALID);
        end
        n_checks++;
        if (SEED_ERR !== 1'b0) begin n_fail++; $display("FAIL n0_serr_clear got %b exp 0", SEED_ERR); end
        n_checks++;
        tick();
        if (DONE !== 1'b0 || BIT_VALID !== 1'b0 || Q !== 16'hBEEF) begin
            n_fail++; $display("FAIL n0_after got d=%b v=%b q=%h exp 0/0/beef", DONE, BIT_VALID, Q);
        end
        n_checks++;
        tick();
    endtask

    task automatic test_abort();
        int dones = 0;
        launch(16'hACE1, 16'd4);
        tick();
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        if (Q !== 16'h7138 || BUSY !== 1'b0 || DONE !== 1'b0 || BIT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL abort got q=%h busy=%b d=%b v=%b exp 7138/0/0/0", Q, BUSY, DONE, BIT_VALID);
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            tick();
            dones += int'(DONE);
        end
        if (dones != 0 || Q !== 16'h7138) begin
            n_fail++; $display("FAIL abort_frozen got dones=%0d q=%h exp 0/7138", dones, Q);
        end
        n_checks++;
        ABORT = 1'b1;
        SEED  = 16'h1234;
        NSTEPS = 16'd2;
        START = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        if (BUSY !== 1'b0 || Q !== 16'h7138) begin
            n_fail++; $display("FAIL abort_blocks_start got busy=%b q=%h exp 0/7138", BUSY, Q);
        end
        n_checks++;
    endtask

    task automatic test_start_ignored();
        launch(16'hACE1, 16'd4);
        tick();
        SEED   = 16'h1234;
        NSTEPS = 16'd1;
        START  = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            if (Q !== exp_q[i]) begin
                n_fail++; $display("FAIL ign_step%0d got %h exp %h", i, Q, exp_q[i]);
            end
            n_checks++;
        end
        tick();
        START = 1'b0;
        if (Q !== 16'h1C4E || BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++; $display("FAIL ign_fin got q=%h busy=%b d=%b exp 1c4e/0/0", Q, BUSY, DONE);
        end
        n_checks++;
        tick();
        if (Q !== 16'h1C4E || BUSY !== 1'b0 || BIT_VALID !== 1'b0) begin
            n_fail++; $display("FAIL ign_idle got q=%h busy=%b v=%b exp 1c4e/0/0", Q, BUSY, BIT_VALID);
        end
        n_checks++;
    endtask

    task automatic test_rst_mid_run();
        int dones = 0;
        launch(16'h0000, 16'd4);
        tick();
        tick();
        if (Q !== 16'h5A00 || SEED_ERR !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre got q=%h e=%b exp 5a00/1", Q, SEED_ERR);
        end
        n_checks++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        if (Q !== 16'h0001 || BUSY !== 1'b0 || SEED_ERR !== 1'b0 || BIT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got q=%h busy=%b e=%b b=%b exp 0001/0/0/0", Q, BUSY, SEED_ERR, BIT_OUT);
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            tick();
            dones += int'(DONE) + int'(BIT_VALID);
        end
        if (dones != 0 || Q !== 16'h0001) begin
            n_fail++; $display("FAIL rst_quiet got events=%0d q=%h exp 0/0001", dones, Q);
        end
        n_checks++;
    endtask

    task automatic test_full_period();
        int  steps = 0;
        bit  seen  = 1'b0;
        launch(16'hACE1, 16'hFFFF);
        for (int i = 0; i < 70000 && !seen; i++) begin
            tick();
            if (BIT_VALID) steps++;
            if (DONE) seen = 1'b1;
        end
        if (!seen) begin n_fail++; $display("FAIL full_timeout got no DONE exp DONE"); end
        n_checks++;
        if (steps != 65535) begin n_fail++; $display("FAIL full_steps got %0d exp 65535", steps); end
        n_checks++;
        if (Q !== 16'hACE1) begin n_fail++; $display("FAIL full_wrap got %h exp ace1", Q); end
        n_checks++;
        tick();
    endtask

    initial begin
        exp_q[0] = 16'hE270; exp_b[0] = 1'b1;
        exp_q[1] = 16'h7138; exp_b[1] = 1'b0;
        exp_q[2] = 16'h389C; exp_b[2] = 1'b0;
        exp_q[3] = 16'h1C4E; exp_b[3] = 1'b0;
        RST    = 1'b1;
        START  = 1'b0;
        SEED   = 16'h0000;
        NSTEPS = 16'h0000;
        HOLD   = 1'b0;
        ABORT  = 1'b0;
        test_reset();
        test_basic_run();
        test_hold();
        test_zero_seed();
        test_nsteps_zero();
        test_abort();
        test_start_ignored();
        test_rst_mid_run();
        test_full_period();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
